add_seq_ctl: RTL

Microsequencer-side controller for the ADD address slice (PC / VA / VA-save / MA datapath). It arbitrates three requesters for the shared 8-bit adder: branch-target load, VA operand update and instruction-buffer PC advance. For each granted operation it drives the adder source selects, register enables and MA latch controls in the correct cycles. It sits between the microsequencer/IB logic and the ADD slice, and it is the only driver of the slice's control inputs.

---
 rtl/add_seq_ctl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/add_seq_ctl.sv
// rtl/add_seq_ctl.sv - ADD slice adder arbiter and control sequencer for PC, VA, VA-save and MA
module add_seq_ctl (
    input  logic       b_clk_l,
    input  logic       reset_h,
    input  logic       br_req_h,
    input  logic       va_req_h,
    input  logic       va_base_h,
    input  logic       va_ma_h,
    input  logic       ib_req_h,
    input  logic [1:0] ib_len_h,
    output logic [2:0] asrc_sel_h,
    output logic [1:0] bsrc_sel_h,
    output logic [1:0] ma_select_h,
    output logic       ena_va_save_l,
    output logic       ena_va_l,
    output logic       ena_pc_l,
    output logic       ena_pc_backup_l,
    output logic       latch_ma_l,
    output logic       aci_l,
    output logic       comp_h,
    output logic       br_done_h,
    output logic       va_done_h,
    output logic       ib_done_h,
    output logic       busy_h
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PC_ADD    = 2'd1,
        PC_COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   is_br, is_br_nxt;

    logic in_commit;
    logic commit_ok;
    logic pend_br;
    logic pend_ib;
    logic va_grant;

    assign in_commit = (state == PC_COMMIT);

    // Commit only while the requester still holds its request, so a dropped
    // request never sees PC change or a done pulse.
    assign commit_ok = in_commit && (is_br ? br_req_h : ib_req_h);

    // The request being completed this cycle is still high; it must not re-launch.
    assign pend_br = br_req_h && !(in_commit && is_br);
    assign pend_ib = ib_req_h && !(in_commit && !is_br);

    // PC_COMMIT does not use the adder, but it owns MA.
    assign va_grant = va_req_h &&
                      ((state == IDLE) || (in_commit && !va_ma_h));

    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            state <= IDLE;
            is_br <= 1'b0;
        end else begin
            state <= state_nxt;
            is_br <= is_br_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        is_br_nxt = is_br;
        case (state)
            IDLE: begin
                if (!va_grant) begin
                    if (pend_br) begin
                        state_nxt = PC_ADD;
                        is_br_nxt = 1'b1;
                    end else if (pend_ib) begin
                        state_nxt = PC_ADD;
                        is_br_nxt = 1'b0;
                    end
                end
            end
            PC_ADD: state_nxt = PC_COMMIT;
            PC_COMMIT: begin
                if (pend_br) begin
                    state_nxt = PC_ADD;
                    is_br_nxt = 1'b1;
                end else if (pend_ib) begin
                    state_nxt = PC_ADD;
                    is_br_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        asrc_sel_h      = 3'b000;
        bsrc_sel_h      = 2'b00;
        ma_select_h     = 2'b00;
        ena_va_save_l   = 1'b1;
        ena_va_l        = 1'b1;
        ena_pc_l        = 1'b1;
        ena_pc_backup_l = 1'b1;
        latch_ma_l      = 1'b1;
        br_done_h       = 1'b0;
        va_done_h       = 1'b0;
        ib_done_h       = 1'b0;

        if (state == PC_ADD) begin
            asrc_sel_h    = is_br ? 3'b100 : {1'b0, ib_len_h};
            bsrc_sel_h    = 2'b01;
            ena_va_save_l = 1'b0;
        end

        if (commit_ok) begin
            ena_pc_l        = 1'b0;
            ena_pc_backup_l = is_br;
            latch_ma_l      = 1'b0;
            ma_select_h     = 2'b10;
            br_done_h       = is_br;
            ib_done_h       = !is_br;
        end

        if (va_grant) begin
            asrc_sel_h = 3'b100;
            bsrc_sel_h = va_base_h ? 2'b11 : 2'b00;
            ena_va_l   = 1'b0;
            va_done_h  = 1'b1;
            if (va_ma_h) begin
                latch_ma_l  = 1'b0;
                ma_select_h = 2'b11;
            end
        end
    end

    assign aci_l  = 1'b1;
    assign comp_h = 1'b0;
    assign busy_h = (state != IDLE);

endmodule
